// File: rtl/shift_reg_sequencer_pkg.sv
// shift_seq_pkg: opcodes, register mode encodings and controller states
package shift_seq_pkg;
    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_SHR  = 3'd1,
        OP_SHL  = 3'd2,
        OP_ROTR = 3'd3,
        OP_ROTL = 3'd4
    } op_e;
    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_SHR  = 2'd1;
    localparam logic [1:0] MODE_SHL  = 2'd2;
    localparam logic [1:0] MODE_LOAD = 2'd3;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;
endpackage

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: drives a universal shift register through load/shift/rotate commands
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic             sr_s1,
    output logic             sr_s0,
    output logic [WIDTH-1:0] sr_data_in,
    output logic             sr_msb_in,
    output logic             sr_lsb_in,
    input  logic             sr_msb_out,
    input  logic             sr_lsb_out,
    output logic             done,
    output logic             err,
    output logic             aborted
);
    import shift_seq_pkg::*;
    state_e           state;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fill_q;
    logic [WIDTH-1:0] data_q;
    logic             err_q;
    logic             ab_q;
    logic             live;
    logic             right;
    logic             shifting;
    logic             loading;
    // command FSM: latch on accept, count down shift steps, abort jumps straight to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            cnt_q  <= '0;
            fill_q <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
            ab_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op_q   <= cmd_op;
                    cnt_q  <= cmd_count;
                    fill_q <= cmd_fill;
                    data_q <= cmd_data;
                    err_q  <= cmd_op > OP_ROTL;
                    ab_q   <= 1'b0;
                    state  <= cmd_op == OP_LOAD ? S_LOAD :
                              (cmd_op <= OP_ROTL && cmd_count != '0) ? S_SHIFT : S_DONE;
                end
                S_LOAD: begin
                    ab_q  <= abort;
                    state <= S_DONE;
                end
                S_SHIFT: if (abort) begin
                    ab_q  <= 1'b1;
                    state <= S_DONE;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    // register pins decode straight from state; rotate feedback is combinational from the pre-edge register
    always_comb begin
        live       = !rst && !abort;
        right      = op_q == OP_SHR || op_q == OP_ROTR;
        shifting   = live && state == S_SHIFT;
        loading    = live && state == S_LOAD;
        {sr_s1, sr_s0} = loading ? MODE_LOAD : shifting ? (right ? MODE_SHR : MODE_SHL) : MODE_HOLD;
        sr_data_in = loading ? data_q : '0;
        sr_msb_in  = (shifting && right) ? (op_q == OP_SHR ? fill_q : sr_lsb_out) : 1'b0;
        sr_lsb_in  = (shifting && !right) ? (op_q == OP_SHL ? fill_q : sr_msb_out) : 1'b0;
        cmd_ready  = !rst && state == S_IDLE;
        done       = !rst && state == S_DONE;
        err        = done && err_q;
        aborted    = done && ab_q;
    end
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer: sequencer driving a 4-bit universal shift register, checked against a command-level model
module tb_shift_reg_sequencer;
    logic       clk = 0;
    logic       rst = 1;
    logic       cmd_valid = 0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 0;
    logic [2:0] cmd_count = 0;
    logic       cmd_fill = 0;
    logic [3:0] cmd_data = 0;
    logic       abort = 0;
    logic       sr_s1, sr_s0, sr_msb_in, sr_lsb_in;
    logic [3:0] sr_data_in;
    logic       done, err, aborted;
    logic [3:0] sr = 4'd0;
    int checks = 0;
    int errors = 0;
    int k;

    always #5 clk = ~clk;

    shift_reg_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_fill(cmd_fill), .cmd_data(cmd_data),
        .abort(abort), .sr_s1(sr_s1), .sr_s0(sr_s0), .sr_data_in(sr_data_in),
        .sr_msb_in(sr_msb_in), .sr_lsb_in(sr_lsb_in), .sr_msb_out(sr[3]), .sr_lsb_out(sr[0]),
        .done(done), .err(err), .aborted(aborted)
    );

    // the 4-bit universal shift register being controlled
    always @(posedge clk) begin
        case ({sr_s1, sr_s0})
            2'd1: sr <= {sr_msb_in, sr[3:1]};
            2'd2: sr <= {sr[2:0], sr_lsb_in};
            2'd3: sr <= sr_data_in;
            default: sr <= sr;
        endcase
    end

    // command-level model: remaining active cycles, pending done, expected register contents
    logic       started = 0;
    logic       m_idle = 1;
    logic       m_done = 0;
    logic       m_err = 0;
    logic       m_ab = 0;
    int         m_left = 0;
    int         m_op = 0;
    logic       m_fill = 0;
    logic [3:0] m_data = 0;
    logic [3:0] exp_reg = 0;

    initial forever begin
        @(posedge clk);
        started = 1;
        if (rst) begin
            m_idle = 1; m_done = 0; m_left = 0;
        end else if (m_done) begin
            m_done = 0; m_idle = 1;
        end else if (m_left > 0) begin
            if (abort) begin
                m_left = 0; m_done = 1; m_ab = 1;
            end else begin
                case (m_op)
                    0: exp_reg = m_data;
                    1: exp_reg = {m_fill, exp_reg[3:1]};
                    2: exp_reg = {exp_reg[2:0], m_fill};
                    3: exp_reg = {exp_reg[0], exp_reg[3:1]};
                    default: exp_reg = {exp_reg[2:0], exp_reg[3]};
                endcase
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1;
            end
        end else if (m_idle && cmd_valid) begin
            m_idle = 0; m_op = int'(cmd_op); m_fill = cmd_fill; m_data = cmd_data;
            m_err = cmd_op > 3'd4; m_ab = 0;
            m_left = cmd_op == 3'd0 ? 1 : cmd_op <= 3'd4 ? int'(cmd_count) : 0;
            if (m_left == 0) m_done = 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_mode();
        if (rst || abort || m_left == 0) return 0;
        if (m_op == 0) return 3;
        return (m_op == 1 || m_op == 3) ? 1 : 2;
    endfunction

    // every-cycle comparison of DUT and register against the model
    always @(negedge clk) begin
        if (started) begin
            chk("mode", int'({sr_s1, sr_s0}), exp_mode());
            chk("ready", int'(cmd_ready), int'(m_idle && !rst));
            chk("done", int'(done), int'(m_done && !rst));
            chk("err", int'(err), int'(m_done && !rst && m_err));
            chk("aborted", int'(aborted), int'(m_done && !rst && m_ab));
            chk("reg", int'(sr), int'(exp_reg));
        end
    end

    task automatic issue(input int op, input int cnt, input bit fill, input logic [3:0] data);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
        cmd_valid = 1; cmd_op = 3'(op); cmd_count = 3'(cnt); cmd_fill = fill; cmd_data = data;
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 30) begin
            @(posedge clk); #1; cyc++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_lit", int'(cmd_ready), 0);
        chk("rst_mode_lit", int'({sr_s1, sr_s0}), 0);
        rst = 0;
        #1;
        chk("idle_ready_lit", int'(cmd_ready), 1);
        issue(0, 0, 0, 4'b1010); wait_done(k);
        chk("load_lat", k, 1); chk("load_reg", int'(sr), 4'b1010);
        chk("load_err", int'(err), 0); chk("load_ab", int'(aborted), 0);
        issue(1, 2, 1, 0); wait_done(k);
        chk("shr_lat", k, 2); chk("shr_reg", int'(sr), 4'b1110);
        issue(0, 0, 0, 4'b1001); wait_done(k);
        issue(4, 3, 0, 0); wait_done(k);
        chk("rotl_lat", k, 3); chk("rotl_reg", int'(sr), 4'b1100);
        issue(2, 0, 1, 0); wait_done(k);
        chk("cnt0_lat", k, 0); chk("cnt0_err", int'(err), 0); chk("cnt0_reg", int'(sr), 4'b1100);
        issue(6, 3, 0, 4'hF); wait_done(k);
        chk("ill_lat", k, 0); chk("ill_err", int'(err), 1); chk("ill_reg", int'(sr), 4'b1100);
        issue(0, 0, 0, 4'b0001); wait_done(k);
        issue(2, 5, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1; #1;
        chk("abort_mode", int'({sr_s1, sr_s0}), 0);
        @(posedge clk); #1;
        abort = 0;
        chk("abort_done", int'(done), 1); chk("abort_flag", int'(aborted), 1);
        chk("abort_reg", int'(sr), 4'b0100);
        @(posedge clk); #1;
        chk("abort_ready", int'(cmd_ready), 1);
        issue(3, 4, 0, 0);
        @(posedge clk); #1;
        rst = 1; #1;
        chk("mrst_mode", int'({sr_s1, sr_s0}), 0); chk("mrst_ready", int'(cmd_ready), 0);
        @(posedge clk); #1;
        rst = 0; #1;
        chk("mrst_ready_after", int'(cmd_ready), 1); chk("mrst_done", int'(done), 0);
        chk("mrst_reg", int'(sr), 4'b0010);
        @(posedge clk); #1;
        chk("mrst_nodone", int'(done), 0);
        issue(3, 7, 0, 0); wait_done(k);
        chk("rotr7_lat", k, 7); chk("rotr7_reg", int'(sr), 4'b0100);
        abort = 1;
        @(posedge clk); #1;
        chk("idle_abort_ready", int'(cmd_ready), 1);
        abort = 0;
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_reg_sequencer.md
Name: shift_reg_sequencer

Overview:
Command-driven controller for the team's 4-bit universal shift register, which has mode selects s1/s0, parallel Data_In and serial MSB_In/LSB_In. It accepts one command at a time over a valid/ready handshake: parallel load, N-step logical shift, or N-step rotate. It drives the register's mode, data and serial-fill pins cycle by cycle and pulses done when the command is finished. It sits between a host/bus agent and the shift register datapath.

Parameters:
WIDTH, 4, register width; sets cmd_data / sr_data_in width.
CNT_W, 3, width of step count; maximum is 2**CNT_W-1 shifts per command.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  operation: 0 LOAD, 1 SHR, 2 SHL, 3 ROTR, 4 ROTL, 5-7 illegal
cmd_count  input  CNT_W  number of shift steps (ignored for LOAD)
cmd_fill  input  1  serial fill bit for SHR/SHL
cmd_data  input  WIDTH  parallel load value
abort  input  1  terminate current command
sr_s1  output  1  register mode select, high bit
sr_s0  output  1  register mode select, low bit
sr_data_in  output  WIDTH  register parallel input
sr_msb_in  output  1  register serial input, right shift
sr_lsb_in  output  1  register serial input, left shift
sr_msb_out  input  1  register bit WIDTH-1
sr_lsb_out  input  1  register bit 0
done  output  1  one-cycle completion pulse
err  output  1  valid with done; illegal op
aborted  output  1  valid with done; command was aborted

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Mode encoding {sr_s1,sr_s0}:
  - 0: hold
  - 1: shift right, sr_msb_in enters the MSB
  - 2: shift left, sr_lsb_in enters the LSB
  - 3: parallel load
- Reset: state IDLE. cmd_ready=0 while rst is high. Mode=0, done=err=aborted=0. sr_data_in, sr_msb_in and sr_lsb_in are 0. All latched command fields are cleared.
- FSM states: IDLE, LOAD, SHIFT, DONE. Mode outputs decode from registered state plus latched command, with no extra pipeline stage.
- IDLE:
  - cmd_ready=1, mode=0.
  - On cmd_valid&cmd_ready: latch op, count, fill and data.
  - Next state: LOAD for op 0; SHIFT for ops 1-4 with count≠0; DONE otherwise (count=0 or illegal op).
  - Illegal op sets err for the DONE cycle.
- LOAD: one cycle, mode=3, sr_data_in=latched data. Next state DONE.
- SHIFT:
  - Step counter loaded with count; decrements every cycle.
  - Mode is 1 for SHR/ROTR and 2 for SHL/ROTL.
  - SHR: sr_msb_in=fill. SHL: sr_lsb_in=fill.
  - ROTR: sr_msb_in=sr_lsb_out. ROTL: sr_lsb_in=sr_msb_out. These paths are combinational and use the pre-edge register value.
  - Exit to DONE after exactly count cycles.
- DONE: one cycle, done=1, mode=0, cmd_ready=0. Next state IDLE.
- Latency: accept edge T0. LOAD updates the register at the end of T1, done in T2. A shift of N updates at the ends of T1..TN, done in T(N+1). The next command can be accepted in T(N+2).
- Throughput: commands never overlap. cmd_valid held during a busy period is ignored until cmd_ready.
- abort:
  - Sampled in LOAD/SHIFT. When high, mode=0 that cycle (no register update), next state DONE with aborted=1.
  - Ignored in IDLE and DONE.
- Simultaneous abort and last SHIFT step: abort wins; the last step is suppressed and aborted=1.
- Reset mid-command: returns to IDLE next edge with mode=0. No done pulse is produced for the killed command.
- Unused serial inputs are driven 0. sr_data_in is 0 outside LOAD.

Decomposition:
- Package shift_seq_pkg holds:
  - op enum (OP_LOAD, OP_SHR, OP_SHL, OP_ROTR, OP_ROTL)
  - mode constants (MODE_HOLD=0, MODE_SHR=1, MODE_SHL=2, MODE_LOAD=3)
  - state enum
- No sub-module: FSM, step counter and output decode live in one module.
- The bench instantiates the existing 4-bit universal shift register alongside this block.

Test Plan:
- Reset then LOAD data=4'b1010 → mode=3 for one cycle, register=1010, done pulse in T2, err=0, aborted=0.
- After load 1010, SHR count=2 fill=1 → mode=1 for 2 cycles, register 1101 then 1110, done in T3.
- After load 1001, ROTL count=3 → register 0011, 0110, 1100; mode=2 throughout; done in T4.
- SHL count=0, then op=6 → each gives done one cycle after accept, no register change, err=0 then err=1.
- After load 0001, SHL count=5 fill=0 with abort asserted in the 3rd SHIFT cycle → register=0100, done with aborted=1, cmd_ready high on the following cycle.
- rst asserted during the 2nd SHIFT cycle of ROTR count=4 → mode=0 and cmd_ready=0 while rst high, state IDLE, no done; cmd_ready=1 the cycle after rst drops.
